// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store stage in front of DataMemory, with read-modify-write for sub-word stores
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);
   localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, WAIT = 3'd2, WR = 3'd3, RESP = 3'd4;
   logic [2:0]  state;
   logic [1:0]  lane, size;
   logic        sgn, we, err;
   logic [31:0] wdata, mask, ext, merged;
   logic [15:0] lane_data;
   logic [4:0]  sh;
   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign mem_read   = state == RD;
   assign mem_write  = state == WR;
   // request error check, lane extraction with extension, and sub-word merge
   always_comb begin
      err       = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
      sh        = {lane, 3'b000};
      mask      = size == 2'b00 ? 32'h0000_00FF << sh : 32'h0000_FFFF << sh;
      lane_data = 16'(mem_read_data >> sh);
      ext       = size == 2'b10 ? mem_read_data :
                  size == 2'b00 ? {{24{sgn & lane_data[7]}}, lane_data[7:0]} :
                                  {{16{sgn & lane_data[15]}}, lane_data};
      merged    = (mem_read_data & ~mask) | ((wdata << sh) & mask);
   end
   // sequencing FSM; strobes and handshakes decode directly from state so reset kills them at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         mem_address    <= '0;
         mem_write_data <= '0;
         resp_rdata     <= '0;
         resp_err       <= 1'b0;
         lane           <= '0;
         size           <= '0;
         sgn            <= 1'b0;
         we             <= 1'b0;
         wdata          <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
               lane           <= req_addr[1:0];
               size           <= req_size;
               sgn            <= req_signed;
               we             <= req_we;
               wdata          <= req_wdata;
               mem_write_data <= req_wdata;
               resp_rdata     <= '0;
               resp_err       <= err;
               state          <= err ? RESP : (req_we && req_size == 2'b10) ? WR : RD;
            end
            RD:   state <= WAIT;
            WAIT: begin
               if (we) begin
                  mem_write_data <= merged;
                  state          <= WR;
               end else begin
                  resp_rdata <= ext;
                  state      <= RESP;
               end
            end
            WR:   state <= RESP;
            RESP: if (resp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
